alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_core.sv | 56 +++++
 rtl/alu_mdu.sv | 184 ++++++++++++++++++
 tb/tb_alu_mdu.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU/MDU slice.
//   - 4-bit ALU operation codes driving alu_core
//   - 3-bit MDU operation codes sampled by alu_mdu on mdu_start
//   - MDU sequencer state type
package alu_pkg;

    // ALU operation encoding (alu_op)
    localparam logic [3:0] ALU_AND     = 4'd0;
    localparam logic [3:0] ALU_OR      = 4'd1;
    localparam logic [3:0] ALU_ADD     = 4'd2;
    localparam logic [3:0] ALU_SUB_BEQ = 4'd3;
    localparam logic [3:0] ALU_SUB_BNE = 4'd4;
    localparam logic [3:0] ALU_SLLV    = 4'd5;
    localparam logic [3:0] ALU_SUB     = 4'd6;
    localparam logic [3:0] ALU_SLT     = 4'd7;
    localparam logic [3:0] ALU_SLTU    = 4'd8;
    localparam logic [3:0] ALU_SRLV    = 4'd9;
    localparam logic [3:0] ALU_SRAV    = 4'd10;
    localparam logic [3:0] ALU_XOR     = 4'd11;
    localparam logic [3:0] ALU_NOR     = 4'd12;
    localparam logic [3:0] ALU_SLL     = 4'd13;
    localparam logic [3:0] ALU_SRL     = 4'd14;
    localparam logic [3:0] ALU_SRA     = 4'd15;

    // MDU operation encoding (mdu_op); codes 6 and 7 are ignored
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    // MDU sequencer states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational integer ALU.
// Ports:
//   alu_op  [3:0]       operation select (see alu_pkg ALU_* codes)
//   reg_a   [WIDTH-1:0] operand A; its low SHW bits are the variable shift amount
//   reg_b   [WIDTH-1:0] operand B; the value being shifted for all shift ops
//   sa      [SHW-1:0]   immediate shift amount (SLL/SRL/SRA)
//   result  [WIDTH-1:0] operation result
//   zero                result == 0 (used for branch compare)
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [SHW-1:0]   sa,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   var_sa;

    assign diff   = reg_a - reg_b;
    assign var_sa = reg_a[SHW-1:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND:     result = reg_a & reg_b;
            ALU_OR:      result = reg_a | reg_b;
            ALU_ADD:     result = reg_a + reg_b;
            // Both branch compares and plain SUB share the subtractor;
            // the branch unit only looks at zero.
            ALU_SUB_BEQ: result = diff;
            ALU_SUB_BNE: result = diff;
            ALU_SUB:     result = diff;
            ALU_SLLV:    result = reg_b << var_sa;
            ALU_SLT:     result = {{(WIDTH-1){1'b0}}, ($signed(reg_a) < $signed(reg_b))};
            ALU_SLTU:    result = {{(WIDTH-1){1'b0}}, (reg_a < reg_b)};
            ALU_SRLV:    result = reg_b >> var_sa;
            ALU_SRAV:    result = $signed(reg_b) >>> var_sa;
            ALU_XOR:     result = reg_a ^ reg_b;
            ALU_NOR:     result = ~(reg_a | reg_b);
            ALU_SLL:     result = reg_b << sa;
            ALU_SRL:     result = reg_b >> sa;
            ALU_SRA:     result = $signed(reg_b) >>> sa;
            default:     result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: ALU plus iterative multiply/divide unit with HI/LO registers.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   alu_op, reg_a,      combinational ALU inputs (reg_a/reg_b also feed the MDU)
//   reg_b, sa
//   result, zero        combinational ALU outputs, independent of MDU state
//   mdu_start, mdu_op   one-cycle request; honoured only while idle
//   flush               abort any in-flight MDU op, HI/LO untouched
//   busy                MDU occupied (RUN or FIX); HI/LO readers must stall
//   done                one-cycle pulse, HI/LO already hold the new result
//   hi, lo              HI/LO architectural registers
//   dbg_state           current sequencer state
//
// Handshake: mdu_start is a single-cycle qualifier sampled on a clock edge
// while busy is low; it is dropped (not queued) while busy is high or when
// flush is high in the same cycle. A multiply/divide holds busy for WIDTH+1
// cycles (WIDTH RUN steps plus one FIX) and pulses done in the cycle after.
//
// Signed ops run on operand magnitudes through an unsigned shift-add /
// restoring shift-subtract datapath; signs are reapplied in FIX.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [SHW-1:0]   sa,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    input  logic             mdu_start,
    input  logic [2:0]       mdu_op,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH) + 1;

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_alu_core (
        .alu_op (alu_op),
        .reg_a  (reg_a),
        .reg_b  (reg_b),
        .sa     (sa),
        .result (result),
        .zero   (zero)
    );

    mdu_state_e       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;     // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] opnd;       // multiplicand / divisor magnitude
    logic             is_div;
    logic             neg_q;      // negate product or quotient in FIX
    logic             neg_r;      // negate remainder in FIX (dividend sign)
    logic             div_zero;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;

    // Operand conditioning at start
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign signed_op = (mdu_op == MDU_MULT) || (mdu_op == MDU_DIV);
    assign a_neg     = signed_op & reg_a[WIDTH-1];
    assign b_neg     = signed_op & reg_b[WIDTH-1];
    // MIN maps to itself, which is the correct unsigned magnitude.
    assign mag_a     = a_neg ? -reg_a : reg_a;
    assign mag_b     = b_neg ? -reg_b : reg_b;

    // Multiply step: conditional add keeps the carry, then shift right.
    logic [WIDTH:0] add_sum;
    assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide step: shift in next dividend bit, trial-subtract divisor.
    // The kept remainder is always < divisor, so WIDTH bits suffice.
    logic [WIDTH:0] shifted;
    logic           sub_ok;
    assign shifted = {acc_hi, acc_lo[WIDTH-1]};
    assign sub_ok  = (shifted >= {1'b0, opnd});

    // Sign correction for the multiply result
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MDU_IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (flush) begin
                state <= MDU_IDLE;
                count <= '0;
            end else begin
                case (state)
                    MDU_IDLE: begin
                        if (mdu_start) begin
                            case (mdu_op)
                                MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                    acc_hi   <= '0;
                                    acc_lo   <= mag_a;
                                    opnd     <= mag_b;
                                    is_div   <= (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
                                    neg_q    <= a_neg ^ b_neg;
                                    neg_r    <= a_neg;
                                    div_zero <= (reg_b == '0);
                                    count    <= CW'(WIDTH);
                                    state    <= MDU_RUN;
                                end
                                MDU_MTHI: hi_r <= reg_a;
                                MDU_MTLO: lo_r <= reg_a;
                                default: ;
                            endcase
                        end
                    end
                    MDU_RUN: begin
                        if (is_div) begin
                            acc_hi <= WIDTH'(sub_ok ? (shifted - {1'b0, opnd}) : shifted);
                            acc_lo <= {acc_lo[WIDTH-2:0], sub_ok};
                        end else begin
                            {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
                        end
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            state <= MDU_FIX;
                        end
                    end
                    MDU_FIX: begin
                        if (is_div) begin
                            // Divide by zero naturally yields an all-ones
                            // magnitude quotient; force it so the quotient
                            // sign fix cannot disturb it.
                            lo_r <= div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
                            hi_r <= neg_r ? -acc_hi : acc_hi;
                        end else begin
                            {hi_r, lo_r} <= prod_fix;
                        end
                        done_r <= 1'b1;
                        state  <= MDU_IDLE;
                    end
                    default: begin
                        state <= MDU_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = (state != MDU_IDLE);
    assign done      = done_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int LAT   = WIDTH + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [SHW-1:0]   sa;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             mdu_start;
    logic [2:0]       mdu_op;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    alu_mdu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .sa        (sa),
        .result    (result),
        .zero      (zero),
        .mdu_start (mdu_start),
        .mdu_op    (mdu_op),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Bench-side view of the architectural HI/LO registers
    logic [WIDTH-1:0] model_hi;
    logic [WIDTH-1:0] model_lo;

    // Scoreboard of expected {hi, lo} for issued multiply/divide ops
    logic [2*WIDTH-1:0] exp_q[$];

    // ---------------- reference models ----------------
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
        int sh;
        sh = int'(a[4:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3, 4'd4, 4'd6: return a - b;
            4'd5:  return b << sh;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return b >> sh;
            4'd10: return $signed(b) >>> sh;
            4'd11: return a ^ b;
            4'd12: return ~(a | b);
            4'd13: return b << s;
            4'd14: return b >> s;
            default: return $signed(b) >>> s;
        endcase
    endfunction

    function automatic logic [63:0] mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint p;
        logic [63:0] u;
        int q;
        int r;
        case (op)
            MDU_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            MDU_MULTU: begin
                u = {32'b0, a} * {32'b0, b};
                return u;
            end
            MDU_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one MDU op and follow it to done. Optionally pulses a second
    // (to-be-ignored) start at cycle mid_start. Reports done cycle
    // (cycle 1 = first cycle after the start edge), busy violations, hi/lo.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mid_start, output int done_cyc, output int busy_bad,
                          output logic [31:0] hi_o, output logic [31:0] lo_o);
        int cyc;
        mdu_op    = op;
        reg_a     = a;
        reg_b     = b;
        mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        cyc       = 1;
        done_cyc  = -1;
        busy_bad  = 0;
        hi_o      = '0;
        lo_o      = '0;
        while (cyc < 60) begin
            if (done) begin
                done_cyc = cyc;
                hi_o     = hi;
                lo_o     = lo;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            if (cyc == mid_start) begin
                mdu_start = 1'b1;
                mdu_op    = MDU_DIVU;
                reg_a     = $urandom;
                reg_b     = $urandom | 32'd1;
            end
            tick();
            mdu_start = 1'b0;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; mdu_start = 1'b0; mdu_op = '0;
        alu_op = '0; reg_a = '0; reg_b = '0; sa = '0;
        tick(); tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", lo); end
        n_vec++; if (dbg_state !== MDU_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, MDU_IDLE); end
        model_hi = '0;
        model_lo = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        logic [31:0] e;
        alu_op = ALU_SRAV; reg_a = 32'd36; reg_b = 32'h8000_0000; #1;
        n_vec++; if (result !== 32'hF800_0000) begin n_err++; $display("FAIL srav_dir got=%h exp=f8000000", result); end
        alu_op = ALU_SUB; reg_a = 32'd5; reg_b = 32'd5; #1;
        n_vec++; if (zero !== 1'b1) begin n_err++; $display("FAIL sub_zero got=%b exp=1", zero); end
        for (int i = 0; i < 300; i++) begin
            alu_op = 4'($urandom_range(0, 15));
            reg_a  = $urandom;
            reg_b  = (i % 5 == 0) ? reg_a : $urandom;
            sa     = 5'($urandom_range(0, 31));
            #1;
            e = alu_ref(alu_op, reg_a, reg_b, sa);
            n_vec++;
            if (result !== e || zero !== (e == 0)) begin
                n_err++;
                $display("FAIL alu_rand op=%0d a=%h b=%h sa=%0d got=%h/%b exp=%h/%b",
                         alu_op, reg_a, reg_b, sa, result, zero, e, (e == 0));
            end
        end
    endtask

    task automatic test_mdu_directed();
        logic [2:0]  t_op[6]  = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_DIVU, MDU_DIV};
        logic [31:0] t_a[6]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h8000_0000};
        logic [31:0] t_b[6]   = '{32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] t_hi[6]  = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'd2, 32'h1234, 32'h0};
        logic [31:0] t_lo[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        int dc, bb;
        logic [31:0] h, l;
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 0, dc, bb, h, l);
            n_vec++; if (dc != LAT) begin n_err++; $display("FAIL dir_latency idx=%0d got=%0d exp=%0d", i, dc, LAT); end
            n_vec++; if (bb != 0) begin n_err++; $display("FAIL dir_busy idx=%0d got=%0d bad cycles exp=0", i, bb); end
            n_vec++; if (h !== t_hi[i] || l !== t_lo[i]) begin
                n_err++; $display("FAIL dir_hilo idx=%0d got=%h_%h exp=%h_%h", i, h, l, t_hi[i], t_lo[i]);
            end
            model_hi = t_hi[i];
            model_lo = t_lo[i];
            tick();
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dir_done_pulse idx=%0d got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_mdu_random();
        logic [2:0]  op;
        logic [31:0] a, b, h, l;
        logic [63:0] e;
        int dc, bb, sel;
        for (int i = 0; i < 24; i++) begin
            op  = 3'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            exp_q.push_back(mdu_ref(op, a, b));
            run_op(op, a, b, 0, dc, bb, h, l);
            e = exp_q.pop_front();
            n_vec++;
            if (dc != LAT || bb != 0 || {h, l} !== e) begin
                n_err++;
                $display("FAIL mdu_rand op=%0d a=%h b=%h got=%h_%h cyc=%0d busybad=%0d exp=%h cyc=%0d",
                         op, a, b, h, l, dc, bb, e, LAT);
            end
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
    endtask

    task automatic test_alu_during_busy();
        logic [31:0] e;
        int cyc;
        mdu_op = MDU_MULTU; reg_a = $urandom; reg_b = $urandom;
        exp_q.push_back(mdu_ref(MDU_MULTU, reg_a, reg_b));
        mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 6; i++) begin
            alu_op = 4'($urandom_range(0, 15));
            reg_a = $urandom; reg_b = $urandom; sa = 5'($urandom_range(0, 31));
            #1;
            e = alu_ref(alu_op, reg_a, reg_b, sa);
            n_vec++; if (result !== e) begin n_err++; $display("FAIL alu_busy op=%0d got=%h exp=%h", alu_op, result, e); end
            tick();
            cyc++;
        end
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        e = 32'(cyc);
        n_vec++;
        if (cyc != LAT || {hi, lo} !== exp_q[0]) begin
            n_err++; $display("FAIL busy_op_result got=%h_%h cyc=%0d exp=%h cyc=%0d", hi, lo, cyc, exp_q[0], LAT);
        end
        {model_hi, model_lo} = exp_q.pop_front();
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v;
        v = $urandom;
        mdu_op = MDU_MTHI; reg_a = v; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        n_vec++; if (hi !== v || lo !== model_lo) begin n_err++; $display("FAIL mthi got=%h_%h exp=%h_%h", hi, lo, v, model_lo); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mthi_flags got=%b%b exp=00", busy, done); end
        model_hi = v;
        v = $urandom;
        mdu_op = MDU_MTLO; reg_a = v; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        n_vec++; if (lo !== v || hi !== model_hi) begin n_err++; $display("FAIL mtlo got=%h_%h exp=%h_%h", hi, lo, model_hi, v); end
        model_lo = v;
        tick();
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mtlo_after got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, h, l;
        logic [63:0] e;
        int dc, bb;
        // start mid-operation must be ignored
        a = $urandom; b = $urandom;
        e = mdu_ref(MDU_MULT, a, b);
        run_op(MDU_MULT, a, b, 5, dc, bb, h, l);
        n_vec++;
        if (dc != LAT || bb != 0 || {h, l} !== e) begin
            n_err++; $display("FAIL ignore_start got=%h_%h cyc=%0d exp=%h cyc=%0d", h, l, dc, e, LAT);
        end
        // next op issued in the done cycle
        a = $urandom; b = 32'($urandom_range(1, 1000));
        e = mdu_ref(MDU_DIV, a, b);
        run_op(MDU_DIV, a, b, 0, dc, bb, h, l);
        n_vec++;
        if (dc != LAT || bb != 0 || {h, l} !== e) begin
            n_err++; $display("FAIL back_to_back got=%h_%h cyc=%0d exp=%h cyc=%0d", h, l, dc, e, LAT);
        end
        {model_hi, model_lo} = e;
        tick();
    endtask

    task automatic test_flush();
        int cyc, dones;
        logic [31:0] a, b, h, l;
        logic [63:0] e;
        int dc, bb;
        mdu_op = MDU_MULT; reg_a = $urandom; reg_b = $urandom; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin tick(); cyc++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL flush_cyc11 got=%b%b exp=00", busy, done); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (done) dones++; end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
        n_vec++; if (hi !== model_hi || lo !== model_lo) begin n_err++; $display("FAIL flush_hilo got=%h_%h exp=%h_%h", hi, lo, model_hi, model_lo); end
        // flush together with start drops the start
        mdu_op = MDU_MULT; mdu_start = 1'b1; flush = 1'b1;
        tick();
        mdu_start = 1'b0; flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
        mdu_op = MDU_MTLO; reg_a = ~model_lo; mdu_start = 1'b1; flush = 1'b1;
        tick();
        mdu_start = 1'b0; flush = 1'b0;
        n_vec++; if (lo !== model_lo) begin n_err++; $display("FAIL flush_mtlo got=%h exp=%h", lo, model_lo); end
        // fresh op after flush
        a = $urandom; b = 32'($urandom_range(1, 50));
        e = mdu_ref(MDU_DIVU, a, b);
        run_op(MDU_DIVU, a, b, 0, dc, bb, h, l);
        n_vec++;
        if (dc != LAT || bb != 0 || {h, l} !== e) begin
            n_err++; $display("FAIL after_flush got=%h_%h cyc=%0d exp=%h cyc=%0d", h, l, dc, e, LAT);
        end
        {model_hi, model_lo} = e;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc, dones;
        mdu_op = MDU_DIV; reg_a = $urandom; reg_b = 32'd3; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        cyc = 1;
        while (cyc < 20) begin tick(); cyc++; end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", hi, lo); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags got=%b%b exp=00", busy, done); end
        model_hi = '0;
        model_lo = '0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (done) dones++; end
        n_vec++; if (dones != 0) begin n_err++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
        mdu_op = MDU_MTLO; reg_a = 32'hA5A5_A5A5; mdu_start = 1'b1;
        tick();
        mdu_start = 1'b0;
        n_vec++; if (lo !== 32'hA5A5_A5A5 || hi !== 32'h0) begin n_err++; $display("FAIL rst_mtlo got=%h_%h exp=0_a5a5a5a5", hi, lo); end
    endtask

    // ---------------- sequencing / report ----------------
    initial begin
        test_reset();
        test_alu();
        test_mdu_directed();
        test_mdu_random();
        test_alu_during_busy();
        test_mthi_mtlo();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
